// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      HOLD
   } fetch_state_t;

   localparam logic [1:0]  PCSRC_PLUS4  = 2'b00;
   localparam logic [1:0]  PCSRC_TARGET = 2'b01;
   localparam logic [1:0]  PCSRC_ALU    = 2'b10;

   localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit_pc_next_mux.sv
// Redirect target selection with word alignment, plus the sequential PC+4 adder.
module pc_next_mux
   import fetch_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic [1:0]            pc_src_i,
   input  logic [ADDR_WIDTH-1:0] pc_target_i,
   input  logic [ADDR_WIDTH-1:0] alu_result_i,
   input  logic [ADDR_WIDTH-1:0] seq_base_i,
   output logic                  redirect_o,
   output logic [ADDR_WIDTH-1:0] redirect_pc_o,
   output logic [ADDR_WIDTH-1:0] seq_pc_o
);

   logic [ADDR_WIDTH-1:0] raw_target;

   // PCSrc=11 is reserved and behaves exactly like "no redirect".
   always_comb begin
      redirect_o = 1'b0;
      raw_target = pc_target_i;
      case (pc_src_i)
         PCSRC_TARGET: begin
            redirect_o = 1'b1;
            raw_target = pc_target_i;
         end
         PCSRC_ALU: begin
            redirect_o = 1'b1;
            raw_target = alu_result_i;
         end
         PCSRC_PLUS4: redirect_o = 1'b0;
         default:     redirect_o = 1'b0;
      endcase
   end

   assign redirect_pc_o = {raw_target[ADDR_WIDTH-1:2], 2'b00};
   assign seq_pc_o      = seq_base_i + ADDR_WIDTH'(4);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues req/gnt/rvalid fetches, and hands
// each word to decode through a one-entry valid/ready register; kills wrong-path fetches.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'hBFC0_0000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            PCSrc,
   input  logic [ADDR_WIDTH-1:0] PCTarget,
   input  logic [ADDR_WIDTH-1:0] ALUResult,
   output logic                  imem_req,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic                  imem_gnt,
   input  logic                  imem_rvalid,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic [DATA_WIDTH-1:0] Instr,
   output logic [ADDR_WIDTH-1:0] PC,
   output logic [ADDR_WIDTH-1:0] PCPlus4
);

   localparam logic [ADDR_WIDTH-1:0] RESET_PC_PLUS4 = RESET_PC + ADDR_WIDTH'(4);

   fetch_state_t          state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
   logic                  discard_q, discard_d;
   logic [DATA_WIDTH-1:0] instr_q, instr_d;
   logic [ADDR_WIDTH-1:0] pc_out_q, pc_out_d;
   logic [ADDR_WIDTH-1:0] pcplus4_q, pcplus4_d;
   logic                  valid_q, valid_d;

   logic                  redirect;
   logic [ADDR_WIDTH-1:0] redirect_pc;
   logic [ADDR_WIDTH-1:0] seq_pc;

   pc_next_mux #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_pc_next_mux (
      .pc_src_i      (PCSrc),
      .pc_target_i   (PCTarget),
      .alu_result_i  (ALUResult),
      .seq_base_i    (req_addr_q),
      .redirect_o    (redirect),
      .redirect_pc_o (redirect_pc),
      .seq_pc_o      (seq_pc)
   );

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_addr_d = req_addr_q;
      discard_d  = discard_q;
      instr_d    = instr_q;
      pc_out_d   = pc_out_q;
      pcplus4_d  = pcplus4_q;
      valid_d    = valid_q;

      case (state_q)
         IDLE: state_d = REQ;
         REQ: begin
            if (redirect) discard_d = 1'b1;
            if (imem_gnt) state_d = WAIT;
         end
         WAIT: begin
            if (imem_rvalid) begin
               if (discard_q || redirect) begin
                  discard_d = 1'b0;
                  state_d   = REQ;
               end else begin
                  instr_d   = imem_rdata;
                  pc_out_d  = req_addr_q;
                  pcplus4_d = seq_pc;
                  valid_d   = 1'b1;
                  pc_d      = seq_pc;
                  state_d   = HOLD;
               end
            end else if (redirect) begin
               discard_d = 1'b1;
            end
         end
         HOLD: begin
            // A redirect kills the held word even if decode accepts it this cycle.
            if (redirect || instr_ready) begin
               valid_d = 1'b0;
               state_d = REQ;
            end
         end
         default: state_d = IDLE;
      endcase

      if (redirect) pc_d = redirect_pc;

      // Latch the request address on entry to REQ from the post-redirect PC.
      if ((state_d == REQ) && (state_q != REQ)) req_addr_d = pc_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         req_addr_q <= RESET_PC;
         discard_q  <= 1'b0;
         instr_q    <= DATA_WIDTH'(NOP_INSTR);
         pc_out_q   <= RESET_PC;
         pcplus4_q  <= RESET_PC_PLUS4;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_addr_q <= req_addr_d;
         discard_q  <= discard_d;
         instr_q    <= instr_d;
         pc_out_q   <= pc_out_d;
         pcplus4_q  <= pcplus4_d;
         valid_q    <= valid_d;
      end
   end

   assign imem_req    = (state_q == REQ);
   assign imem_addr   = req_addr_q;
   assign instr_valid = valid_q;
   assign Instr       = instr_q;
   assign PC          = pc_out_q;
   assign PCPlus4     = pcplus4_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a transaction-level model tracks the
// architectural next PC and which in-flight fetches a redirect has killed.
module tb_fetch_unit;

   localparam int unsigned AW     = 32;
   localparam int unsigned DW     = 32;
   localparam logic [31:0] RST_PC = 32'hBFC0_0000;
   localparam int          W_HOLD = 0;
   localparam int          W_OUT  = 1;
   localparam int          W_REQ  = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [1:0]    PCSrc;
   logic [AW-1:0] PCTarget, ALUResult;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_gnt, imem_rvalid;
   logic [DW-1:0] imem_rdata;
   logic          instr_valid, instr_ready;
   logic [DW-1:0] Instr;
   logic [AW-1:0] PC, PCPlus4;

   always #5 clk = ~clk;

   fetch_unit #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .RESET_PC   (RST_PC)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .PCSrc       (PCSrc),
      .PCTarget    (PCTarget),
      .ALUResult   (ALUResult),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .Instr       (Instr),
      .PC          (PC),
      .PCPlus4     (PCPlus4)
   );

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   // Reference model state
   logic [31:0] model_pc, req_addr_m, out_addr, exp_instr, exp_pc, last_req_seen;
   bit          req_active, req_tainted, outstanding, out_tainted, hold_active, timed_out;
   int unsigned gnt_cnt, rsp_cnt, n_reqs, stall_cnt;

   // Stimulus knobs
   int unsigned gnt_min, gnt_max, rsp_min, rsp_max, ready_pct, redir_pct;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == RST_PC) return 32'h0050_0093;
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic model_reset();
      model_pc    = RST_PC;
      req_addr_m  = '0;
      out_addr    = '0;
      exp_instr   = '0;
      exp_pc      = '0;
      req_active  = 1'b0;
      req_tainted = 1'b0;
      outstanding = 1'b0;
      out_tainted = 1'b0;
      hold_active = 1'b0;
      gnt_cnt     = 0;
      rsp_cnt     = 0;
      stall_cnt   = 0;
   endtask

   task automatic drive_idle();
      PCSrc       = 2'b00;
      PCTarget    = '0;
      ALUResult   = '0;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      instr_ready = 1'b0;
   endtask

   // One clock: observe at negedge, drive inputs, advance the model for the next posedge.
   task automatic step(input bit force_en, input logic [1:0] fsrc,
                       input logic [31:0] ftgt, input logic [31:0] falu);
      bit          redirect;
      logic [31:0] tgt;
      @(negedge clk);
      stall_cnt++;

      check_eq("instr_valid", instr_valid, hold_active);
      if (hold_active) begin
         check_eq("instr_held", Instr, exp_instr);
         check_eq("pc_held", PC, exp_pc);
         check_eq("pcplus4", PCPlus4, exp_pc + 32'd4);
      end
      if (hold_active || outstanding) begin
         check_eq("req_quiet", imem_req, 1'b0);
      end else if (req_active) begin
         check_eq("req_held", imem_req, 1'b1);
         check_eq("req_stable", imem_addr, req_addr_m);
      end else if (imem_req) begin
         req_active    = 1'b1;
         req_tainted   = 1'b0;
         req_addr_m    = model_pc;
         gnt_cnt       = $urandom_range(gnt_max, gnt_min);
         last_req_seen = imem_addr;
         n_reqs++;
         stall_cnt     = 0;
         check_eq("req_addr", imem_addr, model_pc);
      end

      if (force_en) begin
         PCSrc     = fsrc;
         PCTarget  = ftgt;
         ALUResult = falu;
      end else begin
         PCSrc     = ($urandom_range(99, 0) < redir_pct) ? 2'($urandom_range(3, 1)) : 2'b00;
         PCTarget  = $urandom;
         ALUResult = $urandom;
      end
      if (req_active) begin
         imem_gnt = (gnt_cnt == 0);
         if (gnt_cnt != 0) gnt_cnt--;
      end else begin
         imem_gnt = ($urandom_range(3, 0) == 0);
      end
      if (outstanding) begin
         imem_rvalid = (rsp_cnt == 0);
         imem_rdata  = (rsp_cnt == 0) ? mem_word(out_addr) : $urandom;
         if (rsp_cnt != 0) rsp_cnt--;
      end else begin
         imem_rvalid = ($urandom_range(3, 0) == 0);
         imem_rdata  = $urandom;
      end
      instr_ready = ($urandom_range(99, 0) < ready_pct);

      redirect = (PCSrc == 2'b01) || (PCSrc == 2'b10);
      tgt      = ((PCSrc == 2'b01) ? PCTarget : ALUResult) & 32'hFFFF_FFFC;

      if (hold_active && (redirect || instr_ready)) begin
         hold_active = 1'b0;
         stall_cnt   = 0;
      end
      if (outstanding && imem_rvalid) begin
         outstanding = 1'b0;
         stall_cnt   = 0;
         if (!out_tainted && !redirect) begin
            hold_active = 1'b1;
            exp_instr   = mem_word(out_addr);
            exp_pc      = out_addr;
            model_pc    = out_addr + 32'd4;
         end
      end else if (outstanding && redirect) begin
         out_tainted = 1'b1;
      end
      if (req_active && imem_gnt) begin
         req_active  = 1'b0;
         outstanding = 1'b1;
         out_addr    = req_addr_m;
         out_tainted = req_tainted || redirect;
         rsp_cnt     = $urandom_range(rsp_max, rsp_min);
         stall_cnt   = 0;
      end else if (req_active && redirect) begin
         req_tainted = 1'b1;
      end
      if (redirect) model_pc = tgt;

      if (!timed_out && stall_cnt > 60) begin
         timed_out = 1'b1;
         check_eq("progress_timeout", stall_cnt, 0);
      end
   endtask

   function automatic bit met(input int kind, input int unsigned req0);
      case (kind)
         W_HOLD:  return hold_active;
         W_OUT:   return outstanding;
         default: return n_reqs != req0;
      endcase
   endfunction

   task automatic wait_for(input int kind, input int unsigned bound, output int unsigned steps);
      int unsigned req0;
      req0  = n_reqs;
      steps = 0;
      while (!met(kind, req0) && steps < bound) begin
         step(1'b0, 2'b00, '0, '0);
         steps++;
      end
      check_eq("wait_event", met(kind, req0), 1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      int unsigned steps;
      logic [31:0] held_pc;
      n_reqs    = 0;
      timed_out = 1'b0;
      gnt_min = 0; gnt_max = 0; rsp_min = 0; rsp_max = 0;
      ready_pct = 0; redir_pct = 0;
      drive_idle();
      model_reset();

      #12;
      check_eq("rst_req", imem_req, 1'b0);
      check_eq("rst_valid", instr_valid, 1'b0);
      check_eq("rst_instr", Instr, 32'h0000_0013);
      check_eq("rst_pc", PC, RST_PC);
      check_eq("rst_pcplus4", PCPlus4, RST_PC + 32'd4);
      check_eq("rst_addr", imem_addr, RST_PC);
      @(negedge clk);
      rst_n = 1'b1;

      // First fetch with zero-wait memory, then hold decode off for 5 cycles
      wait_for(W_HOLD, 20, steps);
      check_eq("first_latency", steps, 2);
      check_eq("first_req_addr", last_req_seen, RST_PC);
      step(1'b0, 2'b00, '0, '0);
      check_eq("first_instr", Instr, 32'h0050_0093);
      check_eq("first_pc", PC, RST_PC);
      check_eq("first_pcplus4", PCPlus4, RST_PC + 32'd4);
      held_pc = exp_pc;
      repeat (4) step(1'b0, 2'b00, '0, '0);
      ready_pct = 100;
      wait_for(W_REQ, 10, steps);
      check_eq("stall_next_req", last_req_seen, held_pc + 32'd4);

      // Grant delayed by 4 cycles
      gnt_min = 4; gnt_max = 4;
      wait_for(W_HOLD, 40, steps);
      gnt_min = 0; gnt_max = 0;

      // Branch redirect while waiting for the response
      rsp_min = 2; rsp_max = 2;
      wait_for(W_OUT, 40, steps);
      step(1'b1, 2'b01, 32'hBFC0_0040, '0);
      wait_for(W_REQ, 20, steps);
      check_eq("redir_wait_addr", last_req_seen, 32'hBFC0_0040);
      rsp_min = 0; rsp_max = 0;

      // JALR in HOLD with a simultaneous accept
      wait_for(W_HOLD, 40, steps);
      step(1'b1, 2'b10, '0, 32'h0000_0103);
      wait_for(W_REQ, 20, steps);
      check_eq("jalr_addr", last_req_seen, 32'h0000_0100);

      // PC+4 wrap
      step(1'b1, 2'b01, 32'hFFFF_FFFC, '0);
      wait_for(W_REQ, 20, steps);
      check_eq("wrap_req", last_req_seen, 32'hFFFF_FFFC);
      wait_for(W_HOLD, 40, steps);
      step(1'b0, 2'b00, '0, '0);
      check_eq("wrap_pc", PC, 32'hFFFF_FFFC);
      check_eq("wrap_pcplus4", PCPlus4, 32'h0000_0000);
      wait_for(W_REQ, 20, steps);
      check_eq("wrap_next_req", last_req_seen, 32'h0000_0000);

      // Asynchronous reset while holding an instruction
      ready_pct = 0;
      wait_for(W_HOLD, 40, steps);
      step(1'b0, 2'b00, '0, '0);
      check_eq("pre_rst_valid", instr_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      check_eq("async_rst_valid", instr_valid, 1'b0);
      check_eq("async_rst_pc", PC, RST_PC);
      check_eq("async_rst_instr", Instr, 32'h0000_0013);
      check_eq("async_rst_req", imem_req, 1'b0);
      model_reset();
      drive_idle();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      wait_for(W_REQ, 10, steps);
      check_eq("restart_addr", last_req_seen, RST_PC);

      // Randomized traffic
      gnt_min = 0; gnt_max = 4; rsp_min = 0; rsp_max = 4;
      ready_pct = 60; redir_pct = 10;
      repeat (2500) step(1'b0, 2'b00, '0, '0);
      gnt_max = 1; rsp_max = 1; ready_pct = 80; redir_pct = 35;
      repeat (1500) step(1'b0, 2'b00, '0, '0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the decode/control unit. It owns the PC and fetches instructions over a req/gnt/rvalid instruction-memory port. Each fetched word goes to decode through a one-entry valid/ready output register. It also takes the PCSrc-encoded redirects (branch/JAL target, JALR ALU result) and kills wrong-path fetches.

Parameters:
DATA_WIDTH, 32, instruction word width
ADDR_WIDTH, 32, PC / memory address width
RESET_PC, 32'hBFC0_0000, first fetch address after reset

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
PCSrc  input  2  00 no redirect, 01 redirect to PCTarget, 10 redirect to ALUResult, 11 reserved (treated as 00)
PCTarget  input  ADDR_WIDTH  PC+imm target (branch/JAL)
ALUResult  input  ADDR_WIDTH  JALR target
imem_req  output  1  fetch request
imem_addr  output  ADDR_WIDTH  fetch address, word aligned
imem_gnt  input  1  request accepted
imem_rvalid  input  1  response valid
imem_rdata  input  DATA_WIDTH  response instruction
instr_valid  output  1  Instr/PC valid to decode
instr_ready  input  1  decode accepts
Instr  output  DATA_WIDTH  fetched instruction
PC  output  ADDR_WIDTH  address of Instr
PCPlus4  output  ADDR_WIDTH  PC+4, for JAL/JALR link

Behaviour:
- Interface decision: one clock (clk); rst_n is asynchronous, active-low.
- Reset values:
  - State IDLE, pc_q=RESET_PC, req_addr=RESET_PC, discard=0.
  - imem_req=0, instr_valid=0.
  - Instr=32'h0000_0013 (NOP), PC=RESET_PC, PCPlus4=RESET_PC+4.
- Redirect target: selected by PCSrc. Bits [1:0] are forced to 0 (JALR LSB clear; no C extension).
- FSM states:
  - IDLE: imem_req=0. Always moves to REQ next cycle. A redirect sets pc_q.
  - REQ: imem_req=1, imem_addr=req_addr. req_addr is loaded from pc_q on entry and held stable until gnt. On gnt, go to WAIT.
  - WAIT: imem_req=0. On rvalid:
    - if discard, or a redirect occurs this cycle: drop the data, clear discard, go to REQ.
    - otherwise: Instr<=rdata, PC<=req_addr, instr_valid<=1, pc_q<=req_addr+4, go to HOLD.
  - HOLD: instr_valid=1, with Instr and PC held stable. On instr_valid&&instr_ready: instr_valid<=0, go to REQ.
- Redirect priority (PCSrc!=00 in any cycle): pc_q<=target, overriding the +4 update.
  - IDLE/HOLD: go to REQ. instr_valid<=0; any accept in the same cycle is wrong-path and ignored.
  - REQ without gnt: req_addr stays (protocol stability), discard<=1.
  - REQ with gnt: go to WAIT with discard<=1.
  - WAIT without rvalid: discard<=1.
  - The next request after a redirect always uses the new pc_q.
- Latency with zero-wait memory: REQ(gnt) → WAIT(rvalid) → HOLD. Instr is visible 2 cycles after the request is granted. Sustained throughput is 1 instruction per 3 cycles; throughput is not a goal of this block.
- Memory protocol rules:
  - At most one outstanding request.
  - rvalid is ignored outside WAIT.
  - gnt is ignored outside REQ.
- Arithmetic: PC+4 wraps modulo 2^ADDR_WIDTH (FFFF_FFFC → 0000_0000), no flag.
- Reset mid-operation: the state is cleared immediately. The instruction memory shares rst_n, so no stale response may arrive after release.
- PCSrc=11 is never acted on.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {IDLE, REQ, WAIT, HOLD}
  - PCSRC_PLUS4=2'b00, PCSRC_TARGET=2'b01, PCSRC_ALU=2'b10
  - NOP_INSTR=32'h0000_0013
- One natural sub-module, pc_next_mux: combinational target select, alignment and +4.

Test Plan:
- Reset release, memory with 0-wait gnt and 1-cycle rvalid returning 32'h00500093 at BFC00000:
  - imem_addr=BFC00000 on cycle 1.
  - instr_valid=1 with Instr=00500093, PC=BFC00000, PCPlus4=BFC00004.
  - The next request is at BFC00004.
- Downstream instr_ready=0 for 5 cycles: Instr/PC held stable, no new imem_req; accept on cycle 6 leads to a request at PC+4.
- Stalled memory, gnt delayed 4 cycles: imem_addr stays constant while imem_req=1.
- Redirect PCSrc=01, PCTarget=BFC00040 while in WAIT:
  - The returning word is dropped and instr_valid stays 0.
  - The next imem_addr=BFC00040.
- JALR PCSrc=10, ALUResult=0000_0103 in HOLD:
  - Held instr is killed.
  - Next fetch address is 0000_0100.
- rst_n asserted in HOLD: instr_valid→0 and PC→RESET_PC immediately (asynchronous); fetch restarts at RESET_PC; PC+4 wrap check from FFFF_FFFC gives 0000_0000.
